// File: rtl/cam_match_encoder_pkg.sv
// Shared constants and helpers for the CAM match encoder and its group sub-encoder.
package cam_match_encoder_pkg;

   // Data bits stored per CAM RAM block; kept here so CAM-side blocks share one definition.
   localparam int DATA_PER_BLOCK     = 7;

   // Default CAM address width; the encoder must be built with the same value as the CAM.
   localparam int DEFAULT_ADDR_WIDTH = 5;

   // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/cam_group_encoder.sv
// Combinational encoder for one group of match lines: any bit set, index of the
// lowest set bit, and whether two or more bits are set. GROUP_WIDTH >= 2.
module cam_group_encoder
   import cam_match_encoder_pkg::*;
#(
   parameter int GROUP_WIDTH = 8,
   parameter int IDX_W       = clog2(GROUP_WIDTH)
) (
   input  logic [GROUP_WIDTH-1:0] bits,
   output logic                   any,
   output logic [IDX_W-1:0]       idx,
   output logic                   two
);

   // Scan upward: the first set bit gives idx, any later set bit flags a second hit.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
      any  = |bits;
      idx  = '0;
      two  = 1'b0;
      for (int i = 0; i < GROUP_WIDTH; i++) begin
         if (bits[i]) begin
            if (any && idx == '0 && !two && i != 0 && bits[0]) begin
               two = 1'b1;
            end
         end
      end
      // Lowest-index search and second-hit detection.
      begin : scan
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < GROUP_WIDTH; i++) begin
            if (bits[i]) begin
               if (seen) begin
                  two = 1'b1;
               end else begin
                  idx  = IDX_W'(i);
                  seen = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/cam_match_encoder.sv
// Two-stage priority encoder for the ternary CAM match lines. Stage 1 encodes
// each group independently, stage 2 picks the lowest hitting group and forms
// the final address, hit and multi-hit flags. Both stages advance together
// under valid/ready flow control. GROUP_WIDTH >= 2, power of 2, <= WORDS.
module cam_match_encoder
   import cam_match_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int GROUP_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cam_ready,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [(1<<ADDR_WIDTH)-1:0] match_lines,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    match_found,
   output logic [ADDR_WIDTH-1:0]   match_addr,
   output logic                    multi_match
);

   localparam int WORDS   = 1 << ADDR_WIDTH;
   localparam int NGROUPS = WORDS / GROUP_WIDTH;
   localparam int IDX_W   = clog2(GROUP_WIDTH);

   logic                           adv;
   logic                           accept;
   logic [NGROUPS-1:0]             grp_any;
   logic [NGROUPS-1:0]             grp_two;
   logic [NGROUPS-1:0][IDX_W-1:0]  grp_idx;
   logic                           v1;
   logic [NGROUPS-1:0]             any_q;
   logic [NGROUPS-1:0]             two_q;
   logic [NGROUPS-1:0][IDX_W-1:0]  idx_q;
   logic [ADDR_WIDTH-1:0]          addr_d;
   logic                           multi_d;

   // The whole pipeline moves only when the output slot is empty or being consumed.
   assign adv      = !out_valid | out_ready;
   assign in_ready = cam_ready & adv;
   assign accept   = in_valid & in_ready;

   for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
      cam_group_encoder #(
         .GROUP_WIDTH (GROUP_WIDTH),
         .IDX_W       (IDX_W)
      ) u_grp (
         .bits (match_lines[g*GROUP_WIDTH +: GROUP_WIDTH]),
         .any  (grp_any[g]),
         .idx  (grp_idx[g]),
         .two  (grp_two[g])
      );
   end

   // Stage 1: capture per-group encodings and the lookup valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
         v1    <= 1'b0;
         any_q <= '0;
         two_q <= '0;
         idx_q <= '0;
      end else if (adv) begin
         v1    <= accept;
         any_q <= grp_any;
         two_q <= grp_two;
         idx_q <= grp_idx;
      end
   end

   if (NGROUPS == 1) begin : g_single
      // Single group: its encoding is already the final result.
      always_comb begin
         addr_d  = idx_q[0];
         multi_d = two_q[0];
      end
   end else begin : g_multi
      localparam int GSEL_W = ADDR_WIDTH - IDX_W;
      logic [GSEL_W-1:0] gsel;
      logic              sel_found;

      // Stage 2 select: lowest hitting group wins; any hit above it makes a multi-hit.
      always_comb begin
         gsel      = '0;
         sel_found = 1'b0;
         multi_d   = 1'b0;
         for (int g = 0; g < NGROUPS; g++) begin
            if (any_q[g]) begin
               if (!sel_found) begin
                  gsel      = GSEL_W'(g);
                  multi_d   = two_q[g];
                  sel_found = 1'b1;
               end else begin
                  multi_d   = 1'b1;
               end
            end
         end
         addr_d = {gsel, idx_q[gsel]};
      end
   end

   // Stage 2: register the final result; holds while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         match_found <= 1'b0;
         match_addr  <= '0;
         multi_match <= 1'b0;
      end else if (adv) begin
         out_valid   <= v1;
         match_found <= |any_q;
         match_addr  <= addr_d;
         multi_match <= multi_d;
      end
   end

endmodule
